// File: rtl/axi_stream_read_buffered.sv
// axi_stream_read_buffered: AXI-Stream receive side feeding a small
// first-word-fall-through FIFO, drained through a valid/enable pop port.
// Optional macro AXIS_READ_TLAST_EN adds i_tlast/o_last and stores tlast
// alongside each entry; with it undefined the entries hold data only.
module axi_stream_read_buffered #(
    parameter int unsigned BUS_WIDTH = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_areset,
    input  logic                         i_tvalid,
    output logic                         o_tready,
    input  logic [BUS_WIDTH-1:0]         i_tdata,
`ifdef AXIS_READ_TLAST_EN
    input  logic                         i_tlast,
    output logic                         o_last,
`endif
    input  logic                         i_enable,
    output logic                         o_data_valid,
    output logic [BUS_WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef AXIS_READ_TLAST_EN
    localparam int unsigned ENTRY_W = BUS_WIDTH + 1;
`else
    localparam int unsigned ENTRY_W = BUS_WIDTH;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               full_c;
    logic               empty_c;
    logic               push_c;
    logic               pop_c;
    logic [ENTRY_W-1:0] wr_entry_c;
    logic [ENTRY_W-1:0] head_c;

    // Status decoded purely from registered occupancy
    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        empty_c = (count_q == '0);
    end

    // Handshake qualification: push on accepted beat, pop only when non-empty
    always_comb begin
        push_c = i_tvalid && !full_c;
        pop_c  = i_enable && !empty_c;
    end

    // Entry to be written on a push
    always_comb begin
`ifdef AXIS_READ_TLAST_EN
        wr_entry_c = {i_tlast, i_tdata};
`else
        wr_entry_c = i_tdata;
`endif
    end

    // Storage next-state: only the slot under the write pointer changes
    always_comb begin
        mem_d = mem_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = wr_entry_c;
        end
    end

    // Pointer and occupancy next-state; pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards buffered beats at once
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage is intentionally left unreset
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Head entry read out first-word fall-through
    always_comb begin
        head_c = mem_q[rd_ptr_q];
    end

    // Port decode; ready also drops immediately while reset is held
    always_comb begin
        o_tready     = !i_areset && !full_c;
        o_data_valid = !empty_c;
        o_data       = head_c[BUS_WIDTH-1:0];
        o_count      = count_q;
        o_full       = full_c;
`ifdef AXIS_READ_TLAST_EN
        o_last       = head_c[BUS_WIDTH] && !empty_c;
`endif
    end

endmodule

// File: tb/tb_axi_stream_read_buffered.sv
// Self-checking bench for axi_stream_read_buffered: a fixed vector table,
// hand sequences for wrap/reset corners, and random traffic against a queue
// model of the FIFO.
module tb_axi_stream_read_buffered;

    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          i_areset;
    logic          i_tvalid;
    logic          o_tready;
    logic [BW-1:0] i_tdata;
    logic          i_tlast;
    logic          o_last;
    logic          i_enable;
    logic          o_data_valid;
    logic [BW-1:0] o_data;
    logic [2:0]    o_count;
    logic          o_full;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: queue of {tlast, data} in acceptance order
    logic [BW:0] mq[$];

    axi_stream_read_buffered #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_areset     (i_areset),
        .i_tvalid     (i_tvalid),
        .o_tready     (o_tready),
        .i_tdata      (i_tdata),
`ifdef AXIS_READ_TLAST_EN
        .i_tlast      (i_tlast),
        .o_last       (o_last),
`endif
        .i_enable     (i_enable),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_count      (o_count),
        .o_full       (o_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifndef AXIS_READ_TLAST_EN
    assign o_last = 1'b0;
`endif

    typedef struct {
        logic          tv;
        logic [BW-1:0] td;
        logic          en;
        logic          ev;
        logic [BW-1:0] ed;
        logic [2:0]    ec;
        logic          ef;
        logic          et;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the queue model
    task automatic check_model(input string tag);
        chk({tag, "_count"}, 32'(o_count), 32'(mq.size()));
        chk({tag, "_valid"}, 32'(o_data_valid), 32'(mq.size() != 0));
        chk({tag, "_full"},  32'(o_full), 32'(mq.size() == DEPTH));
        chk({tag, "_ready"}, 32'(o_tready), 32'(mq.size() != DEPTH));
        if (mq.size() != 0) begin
            chk({tag, "_data"}, 32'(o_data), 32'(mq[0][BW-1:0]));
        end
`ifdef AXIS_READ_TLAST_EN
        chk({tag, "_last"}, 32'(o_last), 32'((mq.size() != 0) ? mq[0][BW] : 1'b0));
`endif
    endtask

    // Apply one cycle of stimulus, advance the model, check after the edge
    task automatic cycle(input logic tv, input logic [BW-1:0] td, input logic en,
                         input logic tl, input string tag);
        logic do_push;
        logic do_pop;
        i_tvalid = tv;
        i_tdata  = td;
        i_enable = en;
        i_tlast  = tl;
        do_push  = tv && (mq.size() < DEPTH);
        do_pop   = en && (mq.size() > 0);
        @(posedge clk);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back({tl, td});
        #1;
        check_model(tag);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 16'hA5A5, 3'd1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 3'd1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001, 3'd2, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 3'd3, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0001, 3'd4, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0001, 3'd4, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'h0005, 1'b1, 1'b1, 16'h0002, 3'd3, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0002, 3'd4, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h0006, 1'b1, 1'b1, 16'h0003, 3'd3, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 3'd2, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 3'd1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};

        i_areset = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_enable = 1'b0;
        i_tlast  = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", 32'(o_tready), 32'd0);
        chk("rst_valid", 32'(o_data_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_full",  32'(o_full), 32'd0);
        chk("rst_last",  32'(o_last), 32'd0);
        i_areset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(o_tready), 32'd1);

        // Directed table: single beat, empty pop, fill/back-pressure, pop order
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].tv, vecs[i].td, vecs[i].en, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("tab%0d_count", i), 32'(o_count), 32'(vecs[i].ec));
            chk($sformatf("tab%0d_valid", i), 32'(o_data_valid), 32'(vecs[i].ev));
            chk($sformatf("tab%0d_full", i),  32'(o_full), 32'(vecs[i].ef));
            chk($sformatf("tab%0d_ready", i), 32'(o_tready), 32'(vecs[i].et));
            if (vecs[i].ev) begin
                chk($sformatf("tab%0d_data", i), 32'(o_data), 32'(vecs[i].ed));
            end
        end

        // Simultaneous push/pop at count 2 across pointer wrap
        cycle(1'b1, 16'd100, 1'b0, 1'b0, "pp_fill0");
        cycle(1'b1, 16'd101, 1'b0, 1'b0, "pp_fill1");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("pp%0d_head", i), 32'(o_data), 32'(100 + i));
            cycle(1'b1, BW'(102 + i), 1'b1, 1'b0, $sformatf("pp%0d", i));
            chk($sformatf("pp%0d_count", i), 32'(o_count), 32'd2);
        end
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "pp_drain0");
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "pp_drain1");

        // Empty pop then push reads back correctly
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "epop");
        cycle(1'b1, 16'h3C3C, 1'b0, 1'b0, "epop_push");
        chk("epop_data", 32'(o_data), 32'h3C3C);
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "epop_drain");

        // Asynchronous reset mid-operation at count 3
        cycle(1'b1, 16'h0011, 1'b0, 1'b0, "mr0");
        cycle(1'b1, 16'h0022, 1'b0, 1'b0, "mr1");
        cycle(1'b1, 16'h0033, 1'b0, 1'b0, "mr2");
        chk("mr_count3", 32'(o_count), 32'd3);
        i_tvalid = 1'b0;
        i_enable = 1'b0;
        #3;
        i_areset = 1'b1;
        #1;
        chk("mr_valid", 32'(o_data_valid), 32'd0);
        chk("mr_count", 32'(o_count), 32'd0);
        chk("mr_ready", 32'(o_tready), 32'd0);
        mq.delete();
        @(posedge clk);
        #4;
        i_areset = 1'b0;
        #1;
        chk("mr_rel_ready", 32'(o_tready), 32'd1);
        cycle(1'b1, 16'h0BEE, 1'b0, 1'b0, "mr_new");
        chk("mr_new_data", 32'(o_data), 32'h0BEE);
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "mr_drain");

`ifdef AXIS_READ_TLAST_EN
        // tlast carried per entry, zero when empty
        cycle(1'b1, 16'h0101, 1'b0, 1'b0, "tl0");
        cycle(1'b1, 16'h0202, 1'b0, 1'b0, "tl1");
        cycle(1'b1, 16'h0303, 1'b0, 1'b1, "tl2");
        chk("tl_last0", 32'(o_last), 32'd0);
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "tlp0");
        chk("tl_last1", 32'(o_last), 32'd0);
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "tlp1");
        chk("tl_last2", 32'(o_last), 32'd1);
        cycle(1'b0, 16'd0, 1'b1, 1'b0, "tlp2");
        chk("tl_last_empty", 32'(o_last), 32'd0);
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), BW'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_stream_read_buffered.md
# axi_stream_read_buffered

Receiver-side counterpart to the single-beat AXI-Stream writer. Accepts beats from an AXI-Stream master (`tvalid`/`tready`/`tdata`) into a small first-word-fall-through FIFO. Presents them to local logic through a simple valid/enable pop interface. It sits at the ingress of any block that consumes a stream and provides back-pressure so that no beat is ever lost.

## Interface
- `BUS_WIDTH`, 16: data width in bits.
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥ 2.
- `i_clk` input 1: the single clock; all logic on its rising edge.
- `i_areset` input 1: reset, asynchronous and active-high.
- `i_tvalid` input 1: AXI-Stream valid from master.
- `o_tready` output 1: AXI-Stream ready to master.
- `i_tdata` input `BUS_WIDTH`: AXI-Stream data.
- `i_enable` input 1: consumer pop request.
- `o_data_valid` output 1: head entry valid (FIFO not empty).
- `o_data` output `BUS_WIDTH`: head entry data.
- `o_count` output `$clog2(DEPTH+1)`: occupied entries.
- `o_full` output 1: `o_count == DEPTH`.
- `i_tlast` input 1 and `o_last` output 1: present only with `AXIS_READ_TLAST_EN` (see Configuration).

## Operation
- **Storage:** `DEPTH`×`BUS_WIDTH` register array, write pointer `wr_ptr`, read pointer `rd_ptr`, and occupancy `count`.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
- **Push:** occurs when `i_tvalid && o_tready` at a rising edge.
  - `mem[wr_ptr] <= i_tdata`.
  - `wr_ptr` increments.
- **Pop:** occurs when `i_enable && o_data_valid` at a rising edge.
  - `rd_ptr` increments.
  - `i_enable` while empty is ignored; no state changes.
- **Occupancy:**
  - Push only: `count+1`.
  - Pop only: `count-1`.
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
  - Neither: unchanged.
- **Ready:** `o_tready = !i_areset && (count != DEPTH)`.
  - Decoded from registered state only; there is no combinational path from `i_tvalid` or `i_enable`.
  - When full, a same-cycle pop does not raise `o_tready` in that cycle. It rises the following cycle.
- **Output:**
  - `o_data = mem[rd_ptr]`, first-word fall-through.
  - `o_data_valid = (count != 0)`.
  - `o_full = (count == DEPTH)`.
  - `o_count = count`.
- **Ordering:** beats are delivered strictly in acceptance order, with no loss and no duplication.
- **Reset:** asserting `i_areset` at any time, including mid-transfer, immediately clears `count`, `wr_ptr` and `rd_ptr`.
  - Buffered beats are discarded.
  - Memory contents are not cleared.

## Timing
- Outputs during reset and after it: `o_tready`=0 while reset is high. `o_data_valid`=0, `o_full`=0, `o_count`=0, `o_last`=0. `o_data` is don't-care while `o_data_valid`=0.
- First cycle after reset deasserts: `o_tready`=1.
- **Latency:** a beat accepted at edge N appears on `o_data` with `o_data_valid`=1 after edge N, i.e. one cycle of latency, when the FIFO was empty.
- **Pop:** the next entry (or `o_data_valid`=0) is visible after the popping edge.
- **Sustained throughput:** one beat per cycle when the consumer holds `i_enable`=1 and `count` < `DEPTH`.
- **Back-pressure:** with `i_tvalid` held high and no pops, exactly `DEPTH` beats are accepted. `o_tready` falls after the `DEPTH`-th accepting edge.

## Configuration
- **`AXIS_READ_TLAST_EN` defined:**
  - Adds the `i_tlast` input and the `o_last` output.
  - Each FIFO entry stores `BUS_WIDTH+1` bits.
  - `o_last` is the `tlast` of the head entry, qualified by `o_data_valid` (0 when empty).
- **Undefined:**
  - Neither port exists.
  - Entries are `BUS_WIDTH` bits.
  - Behaviour is otherwise identical.

## Test plan
- **Single beat:** after reset, `i_tvalid`=1 with `i_tdata`=16'hA5A5 for one cycle.
  - `o_data_valid`=1 and `o_data`=16'hA5A5 next cycle, `o_count`=1.
  - Pulse `i_enable` → `o_data_valid`=0, `o_count`=0.
- **Fill:** with `DEPTH`=4, stream 0x0001..0x0006 with `i_tvalid` held and no pops.
  - Exactly 0x0001..0x0004 accepted, `o_full`=1, `o_tready`=0.
  - Popping one → `o_tready`=1 next cycle; 0x0005 accepted.
  - Pop order is 1,2,3,4,5.
- **Simultaneous push/pop:** at `o_count`=2, `i_tvalid`=1 and `i_enable`=1 for 10 cycles with incrementing data.
  - `o_count` stays 2.
  - Output sequence is contiguous, crosses pointer wrap, and has no gaps.
- **Empty pop:** `i_enable`=1 with `o_count`=0 → pointers and count unchanged; a following push still reads back correctly.
- **Reset mid-operation:** at `o_count`=3, assert `i_areset` asynchronously between edges.
  - `o_data_valid`, `o_count` and `o_tready` go to 0 immediately.
  - After release, `o_tready`=1 and the first new beat is the first beat read out.
- **`AXIS_READ_TLAST_EN`:** send 3 beats with `tlast`=0,0,1 → `o_last` reads 0,0,1 in order, and `o_last`=0 when empty.
